// File: rtl/coeff_store.sv
// coeff_store: eight banks of 64 x 36-bit filter coefficient words.
// Parallel registered read for the filter bank, serial tap loader for the host.
module coeff_store #(
   parameter int NTAPS = 128,
   parameter int AW    = 6
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [AW-1:0]      coeffaddress,
   output logic [35:0]        coeff0,
   output logic [35:0]        coeff1,
   output logic [35:0]        coeff2,
   output logic [35:0]        coeff3,
   output logic [35:0]        coeff4,
   output logic [35:0]        coeff5,
   output logic [35:0]        coeff6,
   output logic [35:0]        coeff7,
   input  logic               load_start,
   input  logic [2:0]         load_bank,
   input  logic               load_valid,
   input  logic signed [17:0] load_data,
   output logic               load_ready,
   output logic               load_busy,
   output logic               load_done
);

   localparam int NW = NTAPS / 2;

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      DONE
   } state_t;

   state_t        state;
   logic [2:0]    bank;
   logic [AW-1:0] wptr;
   logic [17:0]   lo_hold;
   logic          accept;
   logic [35:0]   mem [8][NW];
   logic [35:0]   rd [8];

   assign accept = load_valid & load_ready;

   // Loader FSM: pairs taps into words, all handshake outputs registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         bank       <= '0;
         wptr       <= '0;
         lo_hold    <= '0;
         load_ready <= 1'b0;
         load_busy  <= 1'b0;
         load_done  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (load_start) begin
                  bank       <= load_bank;
                  wptr       <= '0;
                  state      <= LO;
                  load_ready <= 1'b1;
                  load_busy  <= 1'b1;
               end
            end
            LO: begin
               if (accept) begin
                  lo_hold <= load_data;
                  state   <= HI;
               end
            end
            HI: begin
               if (accept) begin
                  if (wptr == AW'(NW - 1)) begin
                     state      <= DONE;
                     load_ready <= 1'b0;
                     load_done  <= 1'b1;
                  end else begin
                     wptr  <= wptr + 1'b1;
                     state <= LO;
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               load_busy <= 1'b0;
               load_done <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Word write on the second tap of a pair; reset drops a half pair.
   always_ff @(posedge clock) begin
      if (!reset && state == HI && accept) begin
         mem[bank][wptr] <= {load_data, lo_hold};
      end
   end

   // Registered parallel read; the bank under load reads as zero.
   always_ff @(posedge clock) begin
      for (int n = 0; n < 8; n++) begin
         if (reset) begin
            rd[n] <= '0;
         end else if (load_busy && bank == 3'(n)) begin
            rd[n] <= '0;
         end else begin
            rd[n] <= mem[n][coeffaddress];
         end
      end
   end

   assign coeff0 = rd[0];
   assign coeff1 = rd[1];
   assign coeff2 = rd[2];
   assign coeff3 = rd[3];
   assign coeff4 = rd[4];
   assign coeff5 = rd[5];
   assign coeff6 = rd[6];
   assign coeff7 = rd[7];

endmodule

// File: tb/tb_coeff_store.sv
// tb_coeff_store: directed bench for coeff_store.
// Bench keeps its own word model per bank and checks reads, handshakes and timing.
module tb_coeff_store;

   logic        clock;
   logic        reset;
   logic [5:0]  coeffaddress;
   logic [35:0] coeff0, coeff1, coeff2, coeff3;
   logic [35:0] coeff4, coeff5, coeff6, coeff7;
   logic        load_start;
   logic [2:0]  load_bank;
   logic        load_valid;
   logic [17:0] load_data;
   logic        load_ready;
   logic        load_busy;
   logic        load_done;

   coeff_store #(.NTAPS(128), .AW(6)) dut (
      .clock(clock),
      .reset(reset),
      .coeffaddress(coeffaddress),
      .coeff0(coeff0),
      .coeff1(coeff1),
      .coeff2(coeff2),
      .coeff3(coeff3),
      .coeff4(coeff4),
      .coeff5(coeff5),
      .coeff6(coeff6),
      .coeff7(coeff7),
      .load_start(load_start),
      .load_bank(load_bank),
      .load_valid(load_valid),
      .load_data(load_data),
      .load_ready(load_ready),
      .load_busy(load_busy),
      .load_done(load_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [35:0] cf [8];
   always_comb begin
      cf[0] = coeff0;
      cf[1] = coeff1;
      cf[2] = coeff2;
      cf[3] = coeff3;
      cf[4] = coeff4;
      cf[5] = coeff5;
      cf[6] = coeff6;
      cf[7] = coeff7;
   end

   int          errors = 0;
   int          checks = 0;
   int          lat;
   int          ndone;
   int          ra;
   logic [35:0] exp_mem [8][64];
   bit          loaded [8];

   task automatic chk(string tag, logic [35:0] obs, logic [35:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      lat++;
      if (load_done) ndone++;
   endtask

   function automatic logic [17:0] tapv(int seed, int i);
      if (seed == 0) return 18'(i - 64);
      return 18'(i * (2 * seed + 1) * 331 + seed * 4099 + (i << 11));
   endfunction

   // One cycle of the loader with a rolling read address; optional isolation check.
   task automatic rd_tick(int b, bit iso);
      coeffaddress = 6'(ra);
      tick();
      if (iso) begin
         for (int c = 0; c < 8; c++) begin
            if (c == b)
               chk($sformatf("mask_b%0d_a%0d", c, ra), cf[c], 36'd0);
            else if (loaded[c])
               chk($sformatf("iso_b%0d_a%0d", c, ra), cf[c], exp_mem[c][ra]);
         end
      end
      ra = (ra + 1) % 64;
   endtask

   task automatic do_load(int b, int seed, bit bub, bit iso,
                          int start_at, int abort_at);
      int          ntap;
      int          guard;
      bit          acc;
      logic [17:0] v;
      logic [17:0] lo_m;
      lo_m = '0;
      load_bank = 3'(b);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      load_bank = 3'(b + 1);
      lat = 0;
      ndone = 0;
      ra = 0;
      chk("start_ready", {35'd0, load_ready}, 36'd1);
      chk("start_busy", {35'd0, load_busy}, 36'd1);
      ntap = 0;
      guard = 0;
      while (ntap < 128 && ntap != abort_at) begin
         v = tapv(seed, ntap);
         load_data = v;
         load_valid = 1'b1;
         if (ntap == start_at) begin
            load_start = 1'b1;
            load_bank = 3'd6;
         end
         acc = load_ready;
         rd_tick(b, iso);
         load_start = 1'b0;
         if (acc) begin
            if (ntap % 2 == 0) lo_m = v;
            else exp_mem[b][ntap / 2] = {v, lo_m};
            ntap++;
            if (bub && ntap < 128) begin
               load_valid = 1'b0;
               load_data = ~v;
               rd_tick(b, iso);
               chk("bubble_ready", {35'd0, load_ready}, 36'd1);
            end
         end
         guard++;
         if (guard > 1000) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: got %0d taps want 128", ntap);
            break;
         end
      end
      load_valid = 1'b0;
      if (ntap == abort_at) begin
         reset = 1'b1;
         tick();
         reset = 1'b0;
         for (int c = 0; c < 8; c++)
            chk($sformatf("abort_coeff%0d", c), cf[c], 36'd0);
         chk("abort_ready", {35'd0, load_ready}, 36'd0);
         chk("abort_busy", {35'd0, load_busy}, 36'd0);
         chk("abort_done", {35'd0, load_done}, 36'd0);
         return;
      end
      chk("done_pulse", {35'd0, load_done}, 36'd1);
      chk("done_ready", {35'd0, load_ready}, 36'd0);
      chk("done_busy", {35'd0, load_busy}, 36'd1);
      if (!bub) chk("done_latency", 36'(lat), 36'd128);
      load_valid = 1'b1;
      load_data = 18'h2aaaa;
      tick();
      chk("idle_done", {35'd0, load_done}, 36'd0);
      chk("idle_busy", {35'd0, load_busy}, 36'd0);
      chk("idle_ready", {35'd0, load_ready}, 36'd0);
      tick();
      chk("idle_ready2", {35'd0, load_ready}, 36'd0);
      chk("done_count", 36'(ndone), 36'd1);
      load_valid = 1'b0;
      loaded[b] = 1'b1;
   endtask

   task automatic sweep(int b);
      for (int a = 0; a < 64; a++) begin
         coeffaddress = 6'(a);
         tick();
         chk($sformatf("rd_b%0d_a%0d", b, a), cf[b], exp_mem[b][a]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      load_start = 1'b1;
      load_bank = 3'd2;
      load_valid = 1'b0;
      load_data = '0;
      coeffaddress = '0;
      lat = 0;
      ndone = 0;
      ra = 0;
      for (int c = 0; c < 8; c++) loaded[c] = 1'b0;
      tick();
      tick();
      for (int c = 0; c < 8; c++)
         chk($sformatf("reset_coeff%0d", c), cf[c], 36'd0);
      chk("reset_ready", {35'd0, load_ready}, 36'd0);
      chk("reset_busy", {35'd0, load_busy}, 36'd0);
      chk("reset_done", {35'd0, load_done}, 36'd0);
      reset = 1'b0;
      load_start = 1'b0;
      tick();
      chk("reset_start_busy", {35'd0, load_busy}, 36'd0);
      chk("reset_start_ready", {35'd0, load_ready}, 36'd0);

      do_load(3, 0, 1'b0, 1'b0, -1, -1);
      for (int k = 0; k < 64; k++) begin
         coeffaddress = 6'(k);
         tick();
         chk($sformatf("b3_formula_w%0d", k), coeff3,
             {18'(2 * k - 63), 18'(2 * k - 64)});
      end

      do_load(7, 7, 1'b0, 1'b0, -1, -1);
      do_load(6, 6, 1'b0, 1'b0, -1, -1);
      do_load(4, 4, 1'b0, 1'b0, -1, -1);
      do_load(5, 5, 1'b1, 1'b0, -1, -1);
      sweep(5);
      do_load(0, 8, 1'b0, 1'b0, -1, -1);

      do_load(1, 1, 1'b0, 1'b0, 40, -1);
      sweep(1);
      sweep(6);

      do_load(2, 2, 1'b0, 1'b1, -1, -1);
      sweep(2);

      do_load(0, 9, 1'b0, 1'b0, -1, 33);
      sweep(0);
      do_load(0, 10, 1'b0, 1'b0, -1, -1);
      sweep(0);

      coeffaddress = 6'd0;
      tick();
      chk("lat_a0", coeff7, exp_mem[7][0]);
      coeffaddress = 6'd63;
      tick();
      chk("lat_a63", coeff7, exp_mem[7][63]);
      coeffaddress = 6'd1;
      tick();
      chk("lat_a1", coeff7, exp_mem[7][1]);

      for (int a = 0; a < 64; a++) begin
         coeffaddress = 6'(a);
         tick();
         for (int c = 0; c < 8; c++)
            chk($sformatf("final_b%0d_a%0d", c, a), cf[c], exp_mem[c][a]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/coeff_store.md
# coeff_store

Coefficient memory for the 8-channel filter bank. It holds 8 banks of 64 × 36-bit words, one bank per filter. Each word packs two 18-bit taps. The filter bank's `coeffaddress` reads all eight banks in parallel with a registered read. A host-side loader fills one bank at a time from a serial stream of 18-bit taps, using a valid/ready handshake.

## Interface
Parameters:
- `NTAPS`, 128: taps per bank. Must be even. Words per bank = `NTAPS/2` = 64.
- `AW`, 6: word address width.

Ports:
- `clock`  in  1: master clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `coeffaddress`  in  6: read word address from the filter bank.
- `coeff0`..`coeff7`  out  36 each: registered read data for banks 0..7.
- `load_start`  in  1: single-cycle request to begin loading bank `load_bank`.
- `load_bank`  in  3: target bank. Sampled only when `load_start` is accepted.
- `load_valid`  in  1: `load_data` carries a tap.
- `load_data`  in  18 (signed): tap value.
- `load_ready`  out  1: loader accepts a tap this cycle.
- `load_busy`  out  1: a load is in progress.
- `load_done`  out  1: one-cycle pulse when the last tap has been written.

## Operation
- Word format: tap 2k is in bits [17:0] of word k; tap 2k+1 is in bits [35:18]. Taps arrive in order, tap 0 first.
- Memory is not cleared by reset. Contents are undefined until a bank has been loaded.
- Read path:
  - `coeffN <= mem[N][coeffaddress]` every cycle.
  - Exception: if `load_busy` = 1 and N equals the latched bank, `coeffN <= 36'd0`. This masking prevents a filter from mixing old and new coefficients.
- Loader FSM states: IDLE, LO, HI, DONE.
  - **IDLE:** `load_ready` = 0, `load_busy` = 0. On `load_start` = 1:
    - latch `load_bank`;
    - clear the word counter `wptr` to 0;
    - go to LO.
  - **LO:** `load_ready` = 1, `load_busy` = 1. On `load_valid & load_ready`, store `load_data` into the lo holding register and go to HI. Otherwise stay in LO.
  - **HI:** `load_ready` = 1, `load_busy` = 1. On acceptance:
    - write `{load_data, lo_hold}` to `mem[bank][wptr]`;
    - if `wptr` = 63, go to DONE; otherwise increment `wptr` and go to LO.
  - **DONE:** `load_ready` = 0, `load_busy` = 1, `load_done` = 1 for exactly this cycle. Then go to IDLE.
- `load_start` in any state other than IDLE is ignored. It does not restart the load or change the latched bank.
- In IDLE or DONE, `load_valid` is ignored and no data is consumed.
- Gaps in `load_valid` stall the FSM indefinitely. No timeout.
- Width rules: 18-bit taps are stored verbatim with no sign extension or rounding.

## Timing
- Reset values:
  - `coeff0`..`coeff7` = 0;
  - `load_ready` = 0, `load_busy` = 0, `load_done` = 0;
  - FSM in IDLE, `wptr` = 0, lo holding register = 0.
- Read latency: 1 cycle. Address presented at cycle t appears on `coeffN` at t+1.
- Load start:
  - `load_start` at cycle t (in IDLE) makes `load_ready` and `load_busy` = 1 from t+1.
  - The first tap can be accepted at t+1.
- Load throughput: 1 tap per cycle with `load_valid` held high.
  - A full load of 128 taps is accepted over cycles t+1..t+128.
  - `load_done` is high at t+129.
  - `load_busy` falls at t+130.
- Write visibility: a word written at cycle w is readable at cycle w+1.
  - While the bank is masked, reads of it return 0.
  - The first unmasked, valid read data for the loaded bank appears in the cycle after `load_busy` falls.
- Same-cycle read and write of the same word: read-before-write (old data), but the result is masked to 0 anyway.
- Reset mid-load (any state):
  - FSM returns to IDLE next cycle and the outputs take their reset values.
  - Words already written stay in memory; the partial bank is not rolled back.
  - A half-accepted tap pair (in HI) is discarded.
- Simultaneous `reset` and `load_start`: reset wins and no load starts.

## Test plan
- **Full load:** load bank 3 with taps v(i) = i − 64 (i = 0..127), `load_valid` held high. Then sweep `coeffaddress` 0..63. Required:
  - `coeff3` at address k = {18'(2k−63), 18'(2k−64)};
  - `load_done` pulses exactly once, 129 cycles after `load_start`.
- **Backpressure and bubbles:** load bank 5 with `load_valid` toggling 1,0,1,0. Required:
  - identical memory contents to an uninterrupted load;
  - exactly 128 taps consumed;
  - `load_ready` never asserted in IDLE or DONE.
- **Masking and isolation:** while bank 2 is loading, read all addresses. Required:
  - `coeff2` = 0 throughout;
  - banks 0, 1, 3..7 return their previously loaded words with 1-cycle latency.
- **Start while busy:** assert `load_start` with `load_bank` = 6 at tap 40 of a bank-1 load. Required:
  - the start is ignored;
  - all 128 taps go to bank 1;
  - bank 6 is unchanged.
- **Reset mid-load:** assert reset after tap 33 (FSM in HI) while loading bank 0. Required:
  - next cycle all outputs are 0 and `load_ready` = 0;
  - words 0..15 keep the new data and words 16..63 keep the old data;
  - a fresh load afterwards completes normally.
- **Read latency:** with bank 7 loaded, step `coeffaddress` 0, 63, 1. Required: `coeff7` shows `mem[7][0]`, `mem[7][63]`, `mem[7][1]`, each one cycle after its address.
